pll_phase_stepper: RTL and testbench
====================================

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 Parameter STEP_W, default 10, SHALL set the width of the step count.
REQ-002 Parameter PULSE_CYCLES, default 2, SHALL set the number of cycles phase_en is held high per step.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles waited in each phase_done wait state.
REQ-004 One clock; reset is asynchronous and active-low: port clk, input, 1, sole clock (PLL scanclk domain).
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  phase-step command request.
REQ-007 cmd_ready  output  1  command accepted on the cycle cmd_valid && cmd_ready.
REQ-008 cmd_steps  input  STEP_W  unsigned number of phase steps.
REQ-009 cmd_updn  input  1  direction: 1 = advance, 0 = retard.
REQ-010 cmd_cntsel  input  5  PLL counter select.
REQ-011 pll_locked  input  1  PLL lock, asynchronous to clk.
REQ-012 phase_done  input  1  PLL DPS handshake, synchronous to clk; idles high.
REQ-013 phase_en  output  1  DPS step strobe to PLL.
REQ-014 updn  output  1  direction to PLL.
REQ-015 cntsel  output  5  counter select to PLL.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err_code  output  2  completion status, valid while done=1: 0 OK, 1 timeout, 2 lock lost.
REQ-019 steps_done  output  STEP_W  count of steps completed in the current/last command.

Function
REQ-020 pll_locked SHALL pass through a 2-FF synchroniser (lock_s); phase_done SHALL be sampled directly.
REQ-021 FSM states: IDLE, PULSE, WAIT_LOW, WAIT_HIGH, GAP, FINISH.
REQ-022 cmd_ready SHALL equal (state==IDLE) && lock_s.
REQ-023 On accept: latch cmd_steps/updn/cntsel; clear steps_done; if cmd_steps==0 go FINISH with err_code 0, else go PULSE.
REQ-024 updn and cntsel SHALL hold the latched values from accept until the cycle after FINISH, changing only on accept.
REQ-025 PULSE: phase_en=1 for exactly PULSE_CYCLES cycles, then WAIT_LOW.
REQ-026 WAIT_LOW: on phase_done==0 go WAIT_HIGH.
REQ-027 WAIT_HIGH: on phase_done==1 increment steps_done; if steps_done+1==latched steps go FINISH (OK) else go GAP.
REQ-028 GAP SHALL last exactly one cycle, then PULSE.
REQ-029 A per-state cycle counter SHALL clear on entry to WAIT_LOW/WAIT_HIGH; reaching TIMEOUT cycles without the awaited edge SHALL go FINISH with err_code 1.
REQ-030 lock_s==0 in PULSE, WAIT_LOW, WAIT_HIGH or GAP SHALL drop phase_en the same cycle (combinational from state) and go FINISH with err_code 2; lock loss takes priority over timeout and step completion in the same cycle.
REQ-031 FINISH SHALL last one cycle with done=1 and err_code valid, then IDLE.
REQ-032 phase_en SHALL be 1 only in PULSE.
REQ-033 steps_done SHALL never exceed latched steps and SHALL hold its value in IDLE.

Reset
REQ-034 While reset_n==0: state IDLE, phase_en 0, done 0, err_code 0, busy 0, steps_done 0, updn 0, cntsel 0, synchroniser flops 0 (hence cmd_ready 0).
REQ-035 Reset asserted mid-command SHALL abort immediately without a done pulse.

Structure
REQ-036 State encoding enum and err_code constants (ERR_OK, ERR_TIMEOUT, ERR_LOCK) SHALL reside in shared package pll_dps_pkg.
REQ-037 The 2-FF synchroniser SHALL be a sub-module named sync_2ff; all other logic is flat in pll_phase_stepper.

Verification
REQ-038 steps=3, updn=1, cntsel=0, PLL model drops phase_done 2 cycles after phase_en rises and restores 4 cycles later -> three phase_en pulses of 2 cycles each, updn=1, cntsel=0 throughout, done with err_code 0, steps_done=3.
REQ-039 steps=0 accepted -> no phase_en, done the cycle after FINISH entry with err_code 0, steps_done=0.
REQ-040 steps=2, model never lowers phase_done -> done after 255 WAIT_LOW cycles with err_code 1, steps_done=0.
REQ-041 steps=5, pll_locked deasserted during step 3 -> phase_en low within 3 cycles of the pll_locked fall, done with err_code 2, steps_done=2.
REQ-042 pll_locked low at idle, cmd_valid held -> cmd_ready 0, no accept; lock rises -> accept 2-3 cycles later.
REQ-043 reset_n pulsed low during WAIT_HIGH -> all outputs at reset values, no done pulse, next command runs normally.

Source files
------------

// File: rtl/pll_dps_pkg.sv
// Shared definitions for the PLL dynamic phase-shift (DPS) stepper.
//   dps_state_e : FSM state encoding used by pll_phase_stepper
//   ERR_*       : completion status codes reported on err_code while done=1
package pll_dps_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP,
    FINISH
  } dps_state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LOCK    = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both flops clear to 0
//   d       : asynchronous input
//   q       : synchronised output (two cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift handshake for a commanded number of
// steps: phase_en pulse, wait for phase_done low, wait for phase_done high,
// one-cycle gap, repeat. Aborts on timeout or loss of PLL lock.
//   clk, reset_n        : scanclk domain clock, async active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE with lock)
//   cmd_steps/updn/cntsel : step count, direction, PLL counter select
//   pll_locked          : async PLL lock (synchronised internally)
//   phase_done          : PLL DPS handshake, synchronous, idles high
//   phase_en/updn/cntsel: DPS controls to the PLL
//   busy, done, err_code, steps_done : status
module pll_phase_stepper
  import pll_dps_pkg::*;
#(
  parameter int STEP_W       = 10,
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_updn,
  input  logic [4:0]        cmd_cntsel,
  input  logic              pll_locked,
  input  logic              phase_done,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [STEP_W-1:0] steps_done
);

  // One counter serves both the pulse width and the wait timeouts.
  localparam int CNT_MAX = (TIMEOUT > PULSE_CYCLES) ? TIMEOUT : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dps_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_done_d;
  logic [1:0]        err_q, err_d;
  logic              lock_s;
  logic              accept;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    err_d        = err_q;
    steps_done_d = steps_done;
    accept       = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid && lock_s) begin
          accept       = 1'b1;
          steps_done_d = '0;
          if (cmd_steps == '0) begin
            state_d = FINISH;
            err_d   = ERR_OK;
          end else begin
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        if (!lock_s) begin
          state_d = FINISH;
          err_d   = ERR_LOCK;
        end else if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!lock_s) begin
          state_d = FINISH;
          err_d   = ERR_LOCK;
        end else if (!phase_done) begin
          state_d = WAIT_HIGH;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = FINISH;
          err_d   = ERR_TIMEOUT;
        end
      end
      WAIT_HIGH: begin
        if (!lock_s) begin
          state_d = FINISH;
          err_d   = ERR_LOCK;
        end else if (phase_done) begin
          steps_done_d = steps_done + STEP_W'(1);
          if (steps_done_d == steps_q) begin
            state_d = FINISH;
            err_d   = ERR_OK;
          end else begin
            state_d = GAP;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = FINISH;
          err_d   = ERR_TIMEOUT;
        end
      end
      GAP: begin
        if (!lock_s) begin
          state_d = FINISH;
          err_d   = ERR_LOCK;
        end else begin
          state_d = PULSE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change and rests at zero in IDLE.
    cnt_d = (state_d != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= ERR_OK;
      steps_q    <= '0;
      steps_done <= '0;
      updn       <= 1'b0;
      cntsel     <= 5'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      err_q      <= err_d;
      steps_done <= steps_done_d;
      if (accept) begin
        steps_q <= cmd_steps;
        updn    <= cmd_updn;
        cntsel  <= cmd_cntsel;
      end
    end
  end

  // phase_en is gated by lock_s so a lock drop ends the strobe immediately.
  assign phase_en  = (state == PULSE) && lock_s;
  assign cmd_ready = (state == IDLE) && lock_s;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign err_code  = done ? err_q : ERR_OK;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper: a behavioural PLL DPS model,
// a monitor that scores each completion against a queue of expectations,
// and directed scenarios for normal, zero-step, timeout, lock and reset.
module tb_pll_phase_stepper;
  import pll_dps_pkg::*;

  localparam int STEP_W       = 10;
  localparam int PULSE_CYCLES = 2;
  localparam int TIMEOUT      = 255;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_updn;
  logic [4:0]        cmd_cntsel;
  logic              pll_locked;
  logic              phase_done;
  logic              phase_en;
  logic              updn;
  logic [4:0]        cntsel;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic [STEP_W-1:0] steps_done;

  pll_phase_stepper #(
    .STEP_W       (STEP_W),
    .PULSE_CYCLES (PULSE_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_updn   (cmd_updn),
    .cmd_cntsel (cmd_cntsel),
    .pll_locked (pll_locked),
    .phase_done (phase_done),
    .phase_en   (phase_en),
    .updn       (updn),
    .cntsel     (cntsel),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0] err;
    int         steps;
    int         pulses;
    logic       updn;
    logic [4:0] cntsel;
  } exp_t;

  exp_t sb[$];

  // PLL model: phase_done drops 2 cycles after a phase_en rise, restores 4 later.
  logic model_on;
  int   drop_cnt = 0;
  int   rise_cnt = 0;
  logic pe_prev  = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      phase_done = 1'b1;
      drop_cnt   = 0;
      rise_cnt   = 0;
      pe_prev    = 1'b0;
    end else begin
      if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) phase_done = 1'b1;
      end
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) begin
          phase_done = 1'b0;
          rise_cnt   = 4;
        end
      end
      if (model_on && phase_en && !pe_prev) drop_cnt = 2;
      pe_prev = phase_en;
    end
  end

  // Monitor: pulse widths, pulse count, control hold, completion scoring.
  int   pe_run = 0;
  int   pulses = 0;
  int   rises  = 0;
  logic pe_prev_m = 1'b0;
  logic done_prev = 1'b0;
  logic hold_bad  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      pe_run    = 0;
      pulses    = 0;
      rises     = 0;
      pe_prev_m = 1'b0;
      done_prev = 1'b0;
      hold_bad  = 1'b0;
    end else begin
      if (phase_en && !pe_prev_m) rises++;
      if (phase_en) pe_run++;
      else if (pe_run != 0) begin
        check("pe_width", pe_run, PULSE_CYCLES);
        pulses++;
        pe_run = 0;
      end
      if (busy && sb.size() != 0 && (updn !== sb[0].updn || cntsel !== sb[0].cntsel))
        hold_bad = 1'b1;
      if (done) begin
        check("done_1cyc", done_prev, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("err_code", err_code, e.err);
          check("steps_done", steps_done, e.steps);
          check("pulse_count", pulses, e.pulses);
          check("ctrl_hold", hold_bad, 0);
          check("updn", updn, e.updn);
          check("cntsel", cntsel, e.cntsel);
        end
        pulses   = 0;
        rises    = 0;
        hold_bad = 1'b0;
      end
      pe_prev_m = phase_en;
      done_prev = done;
    end
  end

  task automatic push_exp(input int steps, input logic u, input logic [4:0] cs,
                          input logic [1:0] err, input int exp_steps, input int exp_pulses);
    exp_t e;
    e.err    = err;
    e.steps  = exp_steps;
    e.pulses = exp_pulses;
    e.updn   = u;
    e.cntsel = cs;
    sb.push_back(e);
    cmd_steps  = STEP_W'(steps);
    cmd_updn   = u;
    cmd_cntsel = cs;
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic issue_cmd(input int steps, input logic u, input logic [4:0] cs,
                           input logic [1:0] err, input int exp_steps, input int exp_pulses);
    int w;
    push_exp(steps, u, cs, err, exp_steps, exp_pulses);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts negedges from the accepting edge up to and including done.
  task automatic wait_done(input int exp_steps, output int lat);
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    repeat (10) @(negedge clk);
    check("hold_steps_idle", steps_done, exp_steps);
  endtask

  task automatic run_cmd(input int steps, input logic u, input logic [4:0] cs,
                         input logic [1:0] err, input int exp_steps, input int exp_pulses,
                         output int lat);
    issue_cmd(steps, u, cs, err, exp_steps, exp_pulses);
    wait_done(exp_steps, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_updn   = 1'b0;
    cmd_cntsel = 5'd0;
    pll_locked = 1'b1;
    phase_done = 1'b1;
    model_on   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_phase_en", phase_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_steps_done", steps_done, 0);
    check("rst_updn", updn, 0);
    check("rst_cntsel", cntsel, 0);
    check("rst_ready", cmd_ready, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Normal stepping, two direction/select patterns.
    run_cmd(3, 1'b1, 5'd0, ERR_OK, 3, 3, lat);
    run_cmd(2, 1'b0, 5'h13, ERR_OK, 2, 2, lat);

    // Zero steps: straight to FINISH on the cycle after accept.
    run_cmd(0, 1'b1, 5'h0a, ERR_OK, 0, 0, lat);
    check("zero_lat", lat, 1);

    // PLL never answers: 2 pulse cycles + TIMEOUT wait cycles + FINISH.
    model_on = 1'b0;
    run_cmd(2, 1'b0, 5'd7, ERR_TIMEOUT, 0, 1, lat);
    check("timeout_lat", lat, PULSE_CYCLES + TIMEOUT + 1);
    model_on = 1'b1;

    // Lock lost as the third step starts.
    issue_cmd(5, 1'b1, 5'd3, ERR_LOCK, 2, 3);
    w = 0;
    while (rises < 3 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("third_rise_seen", (rises >= 3), 1);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("lock_pe_low", phase_en, 0);
    wait_done(2, lat);

    // No lock at idle: command held but not accepted until lock returns.
    push_exp(1, 1'b1, 5'd2, ERR_OK, 1, 1);
    cmd_valid = 1'b1;
    repeat (8) @(negedge clk);
    check("nolock_ready", cmd_ready, 0);
    check("nolock_busy", busy, 0);
    pll_locked = 1'b1;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("lock_ready_lat", (w >= 2 && w <= 3), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(1, lat);

    // Reset in WAIT_HIGH aborts silently.
    issue_cmd(3, 1'b1, 5'd9, ERR_OK, 3, 3);
    w = 0;
    while (!(busy && !phase_done && !phase_en) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("in_wait_high", (busy && !phase_done), 1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_phase_en", phase_en, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_steps_done", steps_done, 0);
    check("mid_rst_updn", updn, 0);
    check("mid_rst_cntsel", cntsel, 0);
    check("mid_rst_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 0);
    repeat (5) @(negedge clk);
    run_cmd(4, 1'b0, 5'h1f, ERR_OK, 4, 4, lat);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
